uart_tx_fifo_reader: RTL and testbench

UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

---
 rtl/uart_tx_fifo_reader_if.sv | 13 +
 rtl/uart_tx_fifo_reader.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_reader_if.sv
// FIFO-read and UART-line signals of the TX FIFO reader, bundled as one port.
interface uart_tx_fifo_reader_if;
  logic       iEmpty;
  logic [7:0] iRdData;
  logic       oPop;
  logic       oTx;
  logic       oBusy;
  logic       oDone;

  // master: the reader itself; slave: the FIFO/line side that feeds and watches it
  modport master (input iEmpty, input iRdData, output oPop, output oTx, output oBusy, output oDone);
  modport slave  (output iEmpty, output iRdData, input oPop, input oTx, input oBusy, input oDone);
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// UART 8N1 transmitter that pulls bytes from a show-ahead FIFO.
// One byte is popped in IDLE, then START, 8 data bits LSB first, and STOP follow,
// each lasting DIV = CLK_FREQ / BAUD_RATE clocks (DIV must be at least 2).
module uart_tx_fifo_reader #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input logic                   iClk,
  input logic                   iRst,
  uart_tx_fifo_reader_if.master bus
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] baudCnt;
  logic [CNT_W-1:0] baudCntNext;
  logic [2:0]       bitIdx;
  logic [2:0]       bitIdxNext;
  logic [7:0]       shiftReg;
  logic [7:0]       shiftRegNext;
  logic             txReg;
  logic             txNext;
  logic             bitEnd;
  logic             popC;
  logic             busyC;
  logic             doneC;

  assign bitEnd = (baudCnt == CNT_W'(DIV - 1));

  // State register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: each bit phase advances only on its bit-end clock
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (popC) stateNext = START;
      START: if (bitEnd) stateNext = DATA;
      DATA:  if (bitEnd && (bitIdx == 3'd7)) stateNext = STOP;
      STOP:  if (bitEnd) stateNext = IDLE;
    endcase
  end

  // Output decode; pop is gated by reset so nothing is consumed while held in reset
  always_comb begin
    popC  = 1'b0;
    busyC = 1'b0;
    doneC = 1'b0;
    if (iRst && (state == IDLE) && !bus.iEmpty) popC = 1'b1;
    if (state != IDLE) busyC = 1'b1;
    if ((state == STOP) && bitEnd) doneC = 1'b1;
  end

  // Datapath next values; line level follows the bit that will be on the wire next cycle
  always_comb begin
    baudCntNext  = baudCnt;
    bitIdxNext   = bitIdx;
    shiftRegNext = shiftReg;
    unique case (state)
      IDLE: begin
        baudCntNext = '0;
        bitIdxNext  = 3'd0;
        if (popC) shiftRegNext = bus.iRdData;
      end
      START, STOP: begin
        baudCntNext = bitEnd ? '0 : baudCnt + CNT_W'(1);
      end
      DATA: begin
        baudCntNext = bitEnd ? '0 : baudCnt + CNT_W'(1);
        if (bitEnd) begin
          shiftRegNext = {1'b0, shiftReg[7:1]};
          bitIdxNext   = bitIdx + 3'd1;
        end
      end
    endcase
    if (stateNext == START) begin
      txNext = 1'b0;
    end else if (stateNext == DATA) begin
      txNext = shiftRegNext[0];
    end else begin
      txNext = 1'b1;
    end
  end

  // Datapath registers; the line idles high under reset
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      baudCnt  <= '0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'h00;
      txReg    <= 1'b1;
    end else begin
      baudCnt  <= baudCntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftRegNext;
      txReg    <= txNext;
    end
  end

  assign bus.oPop  = popC;
  assign bus.oBusy = busyC;
  assign bus.oDone = doneC;
  assign bus.oTx   = txReg;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader at DIV=16, plus a default-rate instance for bit timing.
module tb_uart_tx_fifo_reader;

  localparam logic [159:0] EXP_DONE = 160'd1 << 159;
  localparam logic [159:0] EXP_BUSY = {160{1'b1}};

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_reader_if bus ();
  uart_tx_fifo_reader_if bus2 ();

  uart_tx_fifo_reader #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .iClk(clk),
    .iRst(rstN),
    .bus (bus.master)
  );

  uart_tx_fifo_reader dutBaud (
    .iClk(clk),
    .iRst(rstN),
    .bus (bus2.master)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         popOnEmpty = 0;
  int         popCycles[$];
  logic [7:0] fifoQ[$];
  logic       noiseOn = 1'b0;
  logic       baudReq = 1'b0;
  logic       popNow;

  // cycle counter, advanced once per falling edge
  always @(negedge clk) cyc++;

  // Show-ahead FIFO model; optional noise on its outputs while a frame is in flight
  always begin
    if (noiseOn && bus.oBusy) begin
      bus.iRdData = 8'($urandom);
      bus.iEmpty  = 1'($urandom);
    end else if (fifoQ.size() > 0) begin
      bus.iEmpty  = 1'b0;
      bus.iRdData = fifoQ[0];
    end else begin
      bus.iEmpty  = 1'b1;
      bus.iRdData = noiseOn ? 8'($urandom) : 8'h00;
    end
    @(negedge clk);
    #4;
    popNow = bus.oPop && rstN;
    if (popNow) popCycles.push_back(cyc);
    @(posedge clk);
    if (popNow) begin
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
      else popOnEmpty++;
    end
    #1;
  end

  // Source for the default-rate instance: one byte 8'h01 on request
  always begin
    bus2.iEmpty  = !baudReq;
    bus2.iRdData = 8'h01;
    @(posedge clk);
    #1;
  end

  function automatic logic [159:0] exp_tx(input logic [7:0] b);
    logic [159:0] r;
    for (int k = 0; k < 160; k++) begin
      if (k < 16) r[k] = 1'b0;
      else if (k < 144) r[k] = b[3'((k - 16) / 16)];
      else r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic wait_pop(input int maxCyc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (bus.oPop) seen = 1'b1;
    end
  endtask

  // Records the 160 frame clocks following the pop cycle
  task automatic capture_frame(output logic [159:0] tx, output logic [159:0] done,
                               output logic [159:0] busy, output logic [159:0] pop,
                               output logic [7:0] dec);
    dec = 8'h00;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      tx[k]   = bus.oTx;
      done[k] = bus.oDone;
      busy[k] = bus.oBusy;
      pop[k]  = bus.oPop;
      if (k >= 16 && k < 144 && ((k % 16) == 8)) dec[3'((k - 16) / 16)] = bus.oTx;
    end
  endtask

  task automatic test_reset();
    fifoQ.push_back(8'hA5);
    repeat (3) @(negedge clk);
    total++; if (bus.oTx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", bus.oTx); end
    total++; if (bus.oPop !== 1'b0) begin bad++; $display("FAIL reset_pop: got %b want 0 (iEmpty=%b)", bus.oPop, bus.iEmpty); end
    total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.oBusy); end
    total++; if (bus.oDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.oDone); end
  endtask

  task automatic test_single();
    logic [159:0] tx, dn, bz, pp;
    logic [7:0]   dec;
    @(negedge clk);
    rstN = 1'b1;
    #1;
    total++; if (bus.oPop !== 1'b1) begin bad++; $display("FAIL single_first_pop: got %b want 1", bus.oPop); end
    capture_frame(tx, dn, bz, pp, dec);
    total++; if (tx !== exp_tx(8'hA5)) begin bad++; $display("FAIL single_tx: got %h want %h", tx, exp_tx(8'hA5)); end
    total++; if (dec !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", dec); end
    total++; if (dn !== EXP_DONE) begin bad++; $display("FAIL single_done: got %h want %h", dn, EXP_DONE); end
    total++; if (bz !== EXP_BUSY) begin bad++; $display("FAIL single_busy: got %h want %h", bz, EXP_BUSY); end
    total++; if (pp !== 160'd0) begin bad++; $display("FAIL single_no_pop: got %h want 0", pp); end
    @(negedge clk);
    total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", bus.oBusy); end
    total++; if (bus.oTx !== 1'b1) begin bad++; $display("FAIL single_tx_after: got %b want 1", bus.oTx); end
    total++; if (bus.oPop !== 1'b0) begin bad++; $display("FAIL single_pop_after: got %b want 0", bus.oPop); end
  endtask

  task automatic test_back_to_back();
    logic [159:0] tx, dn, bz, pp;
    logic [7:0]   dec;
    logic [7:0]   bytes[3];
    logic         seen;
    int           doneCnt;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    doneCnt = 0;
    popCycles.delete();
    for (int i = 0; i < 3; i++) fifoQ.push_back(bytes[i]);
    wait_pop(5, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_start: got no pop want pop within 5 clocks"); return; end
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        @(negedge clk);
        total++; if (bus.oPop !== 1'b1) begin bad++; $display("FAIL b2b_gap_pop%0d: got %b want 1", f, bus.oPop); end
      end
      capture_frame(tx, dn, bz, pp, dec);
      doneCnt += $countones(dn);
      total++; if (dec !== bytes[f]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", f, dec, bytes[f]); end
      total++; if (tx !== exp_tx(bytes[f])) begin bad++; $display("FAIL b2b_tx%0d: got %h want %h", f, tx, exp_tx(bytes[f])); end
    end
    total++; if (doneCnt !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", doneCnt); end
    total++;
    if (popCycles.size() != 3) begin
      bad++; $display("FAIL b2b_pop_count: got %0d want 3", popCycles.size());
    end else begin
      if ((popCycles[1] - popCycles[0]) != 161) begin bad++; $display("FAIL b2b_spacing01: got %0d want 161", popCycles[1] - popCycles[0]); end
      total++;
      if ((popCycles[2] - popCycles[1]) != 161) begin bad++; $display("FAIL b2b_spacing12: got %0d want 161", popCycles[2] - popCycles[1]); end
    end
  endtask

  task automatic test_empty_idle();
    int badPop, badTx, badBusy;
    badPop = 0; badTx = 0; badBusy = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.oPop !== 1'b0) badPop++;
      if (bus.oTx !== 1'b1) badTx++;
      if (bus.oBusy !== 1'b0) badBusy++;
    end
    total++; if (badPop != 0) begin bad++; $display("FAIL idle_pop: got %0d cycles with pop want 0", badPop); end
    total++; if (badTx != 0) begin bad++; $display("FAIL idle_tx: got %0d cycles low want 0", badTx); end
    total++; if (badBusy != 0) begin bad++; $display("FAIL idle_busy: got %0d cycles busy want 0", badBusy); end
  endtask

  task automatic test_data_change();
    logic [159:0] tx, dn, bz, pp;
    logic [7:0]   dec;
    logic         seen;
    noiseOn = 1'b1;
    fifoQ.push_back(8'h96);
    wait_pop(5, seen);
    total++;
    if (!seen) begin bad++; noiseOn = 1'b0; $display("FAIL noise_start: got no pop want pop within 5 clocks"); return; end
    capture_frame(tx, dn, bz, pp, dec);
    total++; if (dec !== 8'h96) begin bad++; $display("FAIL noise_byte: got %h want 96", dec); end
    total++; if (tx !== exp_tx(8'h96)) begin bad++; $display("FAIL noise_tx: got %h want %h", tx, exp_tx(8'h96)); end
    total++; if (pp !== 160'd0) begin bad++; $display("FAIL noise_no_pop: got %h want 0", pp); end
    repeat (3) @(negedge clk);
    noiseOn = 1'b0;
    total++; if (popOnEmpty != 0) begin bad++; $display("FAIL pop_on_empty: got %0d want 0", popOnEmpty); end
  endtask

  task automatic test_reset_mid_frame();
    logic [159:0] tx, dn, bz, pp;
    logic [7:0]   dec;
    logic         seen;
    fifoQ.push_back(8'h5A);
    fifoQ.push_back(8'hC3);
    wait_pop(5, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL rst_mid_start: got no pop want pop within 5 clocks"); return; end
    repeat (69) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    total++; if (bus.oTx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx: got %b want 1", bus.oTx); end
    total++; if (bus.oBusy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.oBusy); end
    total++; if (bus.oPop !== 1'b0) begin bad++; $display("FAIL rst_mid_pop: got %b want 0", bus.oPop); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    total++; if (bus.oPop !== 1'b1) begin bad++; $display("FAIL rst_release_pop: got %b want 1", bus.oPop); end
    capture_frame(tx, dn, bz, pp, dec);
    total++; if (dec !== 8'hC3) begin bad++; $display("FAIL rst_after_byte: got %h want c3", dec); end
    total++; if (tx !== exp_tx(8'hC3)) begin bad++; $display("FAIL rst_after_tx: got %h want %h", tx, exp_tx(8'hC3)); end
    total++; if (dn !== EXP_DONE) begin bad++; $display("FAIL rst_after_done: got %h want %h", dn, EXP_DONE); end
    total++; if (fifoQ.size() != 0) begin bad++; $display("FAIL rst_fifo_left: got %0d want 0", fifoQ.size()); end
  endtask

  task automatic test_bit_timing();
    int  lowCnt, highCnt;
    logic seen;
    lowCnt = 0; highCnt = 0; seen = 1'b0;
    baudReq = 1'b1;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus2.oPop) seen = 1'b1;
    end
    baudReq = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL baud_start: got no pop want pop within 5 clocks"); return; end
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus2.oTx) break;
      lowCnt++;
    end
    highCnt = 1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!bus2.oTx) break;
      highCnt++;
    end
    total++; if (lowCnt != 10416) begin bad++; $display("FAIL baud_start_bit: got %0d want 10416", lowCnt); end
    total++; if (highCnt != 10416) begin bad++; $display("FAIL baud_data_bit: got %0d want 10416", highCnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_idle();
    test_data_change();
    test_reset_mid_frame();
    test_bit_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
